// File: rtl/pair_list_sequencer.sv
// pair_list_sequencer
//
// Accepts one 32-bit pair-list word and replays it as eight 4-bit beats.
// Word layout: list x = [31:16], list y = [15:0]. In each list, pair[1] is
// the upper byte. In each pair, half a is the upper nibble.
// Beat k (0..7) selects list = k[2] ^ Y_FIRST, idx = k[1], half = k[0].
//
// Parameters:
//   Y_FIRST    : 0 = list x is emitted first, 1 = list y is emitted first
//
// Ports:
//   clk        : sole clock, rising edge
//   rst        : synchronous, active-high reset
//   in_data    : pair-list word
//   in_valid   : in_data is offered
//   in_ready   : sequencer is idle and can take a word
//   out_data   : current nibble
//   out_valid  : out_data and the select outputs are valid
//   out_ready  : consumer takes the current beat
//   out_list   : 0 = x, 1 = y
//   out_idx    : pair index within the list
//   out_half   : 0 = a, 1 = b
//   out_parity : XOR of out_data bits (only with PAIR_SEQ_PARITY_EN)
//   out_last   : eighth and final beat of the word
//
// Optional feature macro: PAIR_SEQ_PARITY_EN adds out_parity.
module pair_list_sequencer #(
    parameter int unsigned Y_FIRST = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_list,
    output logic        out_idx,
    output logic        out_half,
`ifdef PAIR_SEQ_PARITY_EN
    output logic        out_parity,
`endif
    output logic        out_last
);

    localparam logic YF = (Y_FIRST != 0);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_reg;
    logic [2:0]  cnt_reg;
    logic [31:0] word_reg;

    logic        in_ready_reg;
    logic        out_valid_reg;
    logic [3:0]  out_data_reg;
    logic        out_list_reg;
    logic        out_idx_reg;
    logic        out_half_reg;
    logic        out_last_reg;
`ifdef PAIR_SEQ_PARITY_EN
    logic        out_parity_reg;
`endif

    // Nibble views of the stored word and of the incoming word, indexed by
    // nibble position (0 = bits [3:0]).
    logic [3:0] word_nib [8];
    logic [3:0] in_nib   [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nib
            assign word_nib[gi] = word_reg[gi*4 +: 4];
            assign in_nib[gi]   = in_data[gi*4 +: 4];
        end
    endgenerate

    // Map a beat number to the nibble position it reads. List x lives in
    // the upper half-word and half a is the upper nibble of a pair, hence
    // the inversions.
    function automatic logic [2:0] beat_pos(input logic [2:0] k);
        logic lst;
        lst = k[2] ^ YF;
        return {~lst, k[1], ~k[0]};
    endfunction

    logic [2:0] cnt_next;
    logic [3:0] first_nib;
    logic [3:0] next_nib;

    always_comb begin
        cnt_next  = cnt_reg + 3'd1;
        first_nib = in_nib[beat_pos(3'd0)];
        next_nib  = word_nib[beat_pos(cnt_next)];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 3'd0;
            word_reg       <= 32'd0;
            in_ready_reg   <= 1'b1;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= 4'd0;
            out_list_reg   <= 1'b0;
            out_idx_reg    <= 1'b0;
            out_half_reg   <= 1'b0;
            out_last_reg   <= 1'b0;
`ifdef PAIR_SEQ_PARITY_EN
            out_parity_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        // Beat 0 is taken straight from in_data so it is
                        // presented on the first BUSY cycle.
                        state_reg      <= BUSY;
                        cnt_reg        <= 3'd0;
                        word_reg       <= in_data;
                        in_ready_reg   <= 1'b0;
                        out_valid_reg  <= 1'b1;
                        out_data_reg   <= first_nib;
                        out_list_reg   <= YF;
                        out_idx_reg    <= 1'b0;
                        out_half_reg   <= 1'b0;
                        out_last_reg   <= 1'b0;
`ifdef PAIR_SEQ_PARITY_EN
                        out_parity_reg <= ^first_nib;
`endif
                    end
                end
                BUSY: begin
                    if (out_ready) begin
                        if (cnt_reg == 3'd7) begin
                            // Final beat taken: one IDLE cycle follows.
                            state_reg      <= IDLE;
                            cnt_reg        <= 3'd0;
                            in_ready_reg   <= 1'b1;
                            out_valid_reg  <= 1'b0;
                            out_data_reg   <= 4'd0;
                            out_list_reg   <= 1'b0;
                            out_idx_reg    <= 1'b0;
                            out_half_reg   <= 1'b0;
                            out_last_reg   <= 1'b0;
`ifdef PAIR_SEQ_PARITY_EN
                            out_parity_reg <= 1'b0;
`endif
                        end else begin
                            cnt_reg        <= cnt_next;
                            out_data_reg   <= next_nib;
                            out_list_reg   <= cnt_next[2] ^ YF;
                            out_idx_reg    <= cnt_next[1];
                            out_half_reg   <= cnt_next[0];
                            out_last_reg   <= (cnt_next == 3'd7);
`ifdef PAIR_SEQ_PARITY_EN
                            out_parity_reg <= ^next_nib;
`endif
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_list   = out_list_reg;
    assign out_idx    = out_idx_reg;
    assign out_half   = out_half_reg;
    assign out_last   = out_last_reg;
`ifdef PAIR_SEQ_PARITY_EN
    assign out_parity = out_parity_reg;
`endif

endmodule

// File: tb/tb_pair_list_sequencer.sv
// Testbench for pair_list_sequencer. Two instances (Y_FIRST = 0 and 1) share
// the same input stimulus; each word is checked beat by beat against
// hand-computed nibble sequences. Inputs change and outputs are sampled on
// the falling edge.
module tb_pair_list_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready_a,  in_ready_b;
    logic [3:0]  out_data_a,  out_data_b;
    logic        out_valid_a, out_valid_b;
    logic        out_list_a,  out_list_b;
    logic        out_idx_a,   out_idx_b;
    logic        out_half_a,  out_half_b;
    logic        out_last_a,  out_last_b;
`ifdef PAIR_SEQ_PARITY_EN
    logic        out_parity_a, out_parity_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pair_list_sequencer #(.Y_FIRST(0)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .out_data(out_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_list(out_list_a), .out_idx(out_idx_a),
        .out_half(out_half_a),
`ifdef PAIR_SEQ_PARITY_EN
        .out_parity(out_parity_a),
`endif
        .out_last(out_last_a)
    );

    pair_list_sequencer #(.Y_FIRST(1)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_list(out_list_b), .out_idx(out_idx_b),
        .out_half(out_half_b),
`ifdef PAIR_SEQ_PARITY_EN
        .out_parity(out_parity_b),
`endif
        .out_last(out_last_b)
    );

    // One word: expected nibble sequences (beat 0 in bits [31:28]) for
    // Y_FIRST = 0 and 1, an optional stall and optional junk input in BUSY.
    typedef struct {
        string       name;
        logic [31:0] word;
        logic [31:0] seq_x;
        logic [31:0] seq_y;
        int          stall_at;
        int          stall_n;
        bit          junk;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] seq_nib(input logic [31:0] seq, input int k);
        logic [31:0] s;
        s = seq >> (28 - 4 * k);
        return s[3:0];
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, " in_ready_a"},  {31'd0, in_ready_a},  32'd1);
        chk({tag, " out_valid_a"}, {31'd0, out_valid_a}, 32'd0);
        chk({tag, " out_data_a"},  {28'd0, out_data_a},  32'd0);
        chk({tag, " out_last_a"},  {31'd0, out_last_a},  32'd0);
        chk({tag, " in_ready_b"},  {31'd0, in_ready_b},  32'd1);
        chk({tag, " out_valid_b"}, {31'd0, out_valid_b}, 32'd0);
    endtask

    task automatic check_beat(input string tag, input int k,
                              input logic [31:0] sx, input logic [31:0] sy);
        logic [2:0] kb;
        logic [3:0] ex, ey;
        kb = 3'(k);
        ex = seq_nib(sx, k);
        ey = seq_nib(sy, k);
        chk($sformatf("%s k%0d in_ready_a", tag, k),  {31'd0, in_ready_a},  32'd0);
        chk($sformatf("%s k%0d out_valid_a", tag, k), {31'd0, out_valid_a}, 32'd1);
        chk($sformatf("%s k%0d out_data_a", tag, k),  {28'd0, out_data_a},  {28'd0, ex});
        chk($sformatf("%s k%0d out_list_a", tag, k),  {31'd0, out_list_a},  {31'd0, kb[2]});
        chk($sformatf("%s k%0d out_idx_a", tag, k),   {31'd0, out_idx_a},   {31'd0, kb[1]});
        chk($sformatf("%s k%0d out_half_a", tag, k),  {31'd0, out_half_a},  {31'd0, kb[0]});
        chk($sformatf("%s k%0d out_last_a", tag, k),  {31'd0, out_last_a},  {31'd0, (k == 7)});
        chk($sformatf("%s k%0d in_ready_b", tag, k),  {31'd0, in_ready_b},  32'd0);
        chk($sformatf("%s k%0d out_valid_b", tag, k), {31'd0, out_valid_b}, 32'd1);
        chk($sformatf("%s k%0d out_data_b", tag, k),  {28'd0, out_data_b},  {28'd0, ey});
        chk($sformatf("%s k%0d out_list_b", tag, k),  {31'd0, out_list_b},  {31'd0, ~kb[2]});
        chk($sformatf("%s k%0d out_last_b", tag, k),  {31'd0, out_last_b},  {31'd0, (k == 7)});
`ifdef PAIR_SEQ_PARITY_EN
        chk($sformatf("%s k%0d out_parity_a", tag, k), {31'd0, out_parity_a}, {31'd0, ^ex});
        chk($sformatf("%s k%0d out_parity_b", tag, k), {31'd0, out_parity_b}, {31'd0, ^ey});
`endif
    endtask

    // Wait (bounded) for the sequencer to be idle, then offer a word.
    task automatic offer_word(input string tag, input logic [31:0] w);
        int n;
        n = 0;
        while (!in_ready_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_a) begin
            chk({tag, " wait in_ready timeout"}, {31'd0, in_ready_a}, 32'd1);
        end
        in_data   = w;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        offer_word(v.name, v.word);
        if (v.junk) begin
            in_data  = 32'hFFFF_FFFF;
            in_valid = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            if (k == v.stall_at) begin
                for (int s = 0; s < v.stall_n; s++) begin
                    out_ready = 1'b0;
                    check_beat({v.name, " stall"}, k, v.seq_x, v.seq_y);
                    @(negedge clk);
                end
            end
            out_ready = 1'b1;
            check_beat(v.name, k, v.seq_x, v.seq_y);
            if (k == 7) in_valid = 1'b0;
            @(negedge clk);
        end
        // The cycle after the last beat is the single IDLE cycle.
        check_idle({v.name, " after"});
        $display("word %s %08h done: checks=%0d errors=%0d", v.name, v.word, checks, errors);
    endtask

    initial begin
        vecs[0] = '{"basic",    32'h1234_5678, 32'h3412_7856, 32'h7856_3412, -1, 0, 1'b0};
        vecs[1] = '{"mixed",    32'h9ABC_DEF0, 32'hBC9A_F0DE, 32'hF0DE_BC9A, -1, 0, 1'b0};
        vecs[2] = '{"zero",     32'h0000_0000, 32'h0000_0000, 32'h0000_0000, -1, 0, 1'b0};
        vecs[3] = '{"ones",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0, 1'b0};
        vecs[4] = '{"backpres", 32'h1234_5678, 32'h3412_7856, 32'h7856_3412,  2, 3, 1'b0};
        vecs[5] = '{"busyjunk", 32'hA5C3_1E7F, 32'hC3A5_7F1E, 32'h7F1E_C3A5, -1, 0, 1'b1};

        rst       = 1'b1;
        in_data   = 32'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle("reset");
        out_ready = 1'b1;       // out_ready alone must not start anything
        @(negedge clk);
        check_idle("reset+1");
`ifdef PAIR_SEQ_PARITY_EN
        chk("reset out_parity_a", {31'd0, out_parity_a}, 32'd0);
`endif
        $display("reset done: checks=%0d errors=%0d", checks, errors);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Reset in the middle of a word, after beat 4 is consumed.
        offer_word("midrst", 32'h1234_5678);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_beat("midrst", k, 32'h3412_7856, 32'h7856_3412);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("midrst after rst");
        $display("reset mid-word: checks=%0d errors=%0d", checks, errors);
        run_vec(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
